pool_fmap_buffer: RTL and testbench
===================================

# pool_fmap_buffer

Downstream stage of the max-pooling block: captures each pooled 32-bit result on its valid strobe, writes it raster-order into an on-chip feature-map RAM of OUT_W x OUT_H words, and flags frame completion. Once a frame is complete, the next stage or host reads the map through a registered read port. It isolates the streaming pool output from the random-access consumer of the next layer.

## Interface
- DATA_W, 32, word width; matches the pool output.
- OUT_W, 14, pooled map width (columns).
- OUT_H, 14, pooled map height (rows).
- ADDR_W, 8, address width; must satisfy 2^ADDR_W >= OUT_W*OUT_H.
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  stage enable; writes are accepted only when high.
- in_valid  input  1  pool result valid; driven by the pool stage's max_enable.
- in  input  DATA_W  pooled word.
- clear  input  1  synchronous; restarts frame capture.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_W  read word address, raster order (row*OUT_W+col).
- rd_data  output  DATA_W  read data, registered.
- rd_valid  output  1  one-cycle strobe qualifying rd_data.
- frame_done  output  1  level; map complete and readable.
- wr_col  output  ADDR_W  current write column.
- wr_row  output  ADDR_W  current write row.
- overflow  output  1  sticky; a write arrived while the frame was complete.

## Operation
- States: FILL, DONE. Reset and clear both enter FILL.
- FILL: a write occurs when enable && in_valid. The word goes to mem[wr_row*OUT_W+wr_col]. wr_col then increments. At OUT_W-1, wr_col wraps to 0 and wr_row increments.
- The write of the last pixel (wr_row=OUT_H-1, wr_col=OUT_W-1) moves the FSM to DONE on that same edge. The counters wrap to 0,0 and frame_done=1 from the next cycle.
- DONE: writes are dropped and memory is untouched. Any enable && in_valid sets overflow, which stays set until reset or clear.
- Reads are serviced only in DONE. rd_en=1 gives rd_data=mem[rd_addr] and rd_valid=1 on the next cycle.
- rd_en while in FILL is ignored. rd_valid stays 0 and rd_data holds its previous value.
- rd_addr >= OUT_W*OUT_H in DONE returns rd_data=0 with rd_valid=1.
- clear in either state:
  - next state FILL; wr_col, wr_row, overflow and frame_done go to 0;
  - memory contents are kept;
  - clear wins over a simultaneous write (the pixel is dropped) and over a simultaneous read (no rd_valid).
- enable low freezes writes only. Reads in DONE still work.
- No arithmetic on data beyond the optional clamp. Address multiply is constant-width ADDR_W, truncated.

## Timing
- Reset values: rd_data=0, rd_valid=0, frame_done=0, wr_col=0, wr_row=0, overflow=0, state=FILL. Memory is not reset.
- Reset asserted mid-frame aborts the frame immediately (asynchronous). The partial map is discarded logically.
- Write latency: a word written at edge N is readable by a rd_en issued at edge N+1 or later (DONE only).
- Read latency: exactly 1 cycle. Back-to-back rd_en on consecutive cycles gives consecutive rd_valid strobes (full throughput).
- Writes are accepted every cycle in FILL (full throughput). There is no backpressure, and the upstream stage never stalls.

## Configuration
- POOL_FMAP_RELU_EN defined: a word with bit DATA_W-1 set is stored as all zeros. This applies the ReLU clamp for both two's-complement and sign-magnitude/float encodings.
- POOL_FMAP_RELU_EN undefined: words are stored unchanged.
- The macro has no effect on timing or counters.

## Structure
- Shared package holds:
  - FSM state typedef (FILL, DONE);
  - default OUT_W/OUT_H/DATA_W constants, shared with the pool stage so map geometry is defined once.
- One sub-module: pool_fmap_ram, a single-clock simple dual-port RAM (1 write port, 1 registered read port), DEPTH=OUT_W*OUT_H, no reset on the array.
- Top level holds the FSM, the counters, the clamp and the address-range check.

## Test plan
- Reset, then stream 196 words 0..195 with in_valid every cycle → frame_done rises the cycle after word 195. Reading addresses 0..195 back-to-back returns 0..195, each with rd_valid, 1-cycle latency.
- Streaming with enable toggling every other cycle → only enable-high words are stored; wr_col/wr_row advance only on accepted words. Check the wrap at col 13→0, row+1.
- In DONE, send 3 extra in_valid words → overflow=1 and sticky. Reading address 0 still returns the original word. clear → overflow=0, frame_done=0, wr_col=wr_row=0.
- rd_en during FILL → rd_valid=0. In DONE, rd_addr=200 → rd_data=0, rd_valid=1.
- clear asserted on the same cycle as the 196th write → FSM stays in FILL, frame_done stays 0, counters are 0. Assert reset mid-frame at word 50 → all outputs are 0 immediately.
- With POOL_FMAP_RELU_EN, write 0x8000_0001 and 0x7FFF_FFFF → they read back as 0x0000_0000 and 0x7FFF_FFFF. Without the macro, they read back unchanged.

Source files
------------

// File: rtl/pool_fmap_buffer_pkg.sv
// Shared geometry and FSM encoding for the pooled feature-map buffer.
// The pool stage imports the same constants, so the map geometry is defined once.
package pool_fmap_buffer_pkg;

    localparam int POOL_DATA_W = 32;
    localparam int POOL_OUT_W  = 14;
    localparam int POOL_OUT_H  = 14;
    localparam int POOL_ADDR_W = 8;

    typedef logic [0:0] fmap_state_t;

    localparam fmap_state_t ST_FILL = 1'b0;
    localparam fmap_state_t ST_DONE = 1'b1;

endpackage

// File: rtl/pool_fmap_ram.sv
// Simple dual-port feature-map RAM: one write port and one registered read port.
// Only the read register is reset; the array itself is not.
module pool_fmap_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 196
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pool_fmap_buffer.sv
// Pooled feature-map buffer: raster-order frame capture with a registered read port.
// Define POOL_FMAP_RELU_EN to store negative words (MSB set) as zero.
module pool_fmap_buffer
    import pool_fmap_buffer_pkg::*;
#(
    parameter int DATA_W = POOL_DATA_W,
    parameter int OUT_W  = POOL_OUT_W,
    parameter int OUT_H  = POOL_OUT_H,
    parameter int ADDR_W = POOL_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in,
    input  logic              clear,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              frame_done,
    output logic [ADDR_W-1:0] wr_col,
    output logic [ADDR_W-1:0] wr_row,
    output logic              overflow
);

    localparam int                DEPTH    = OUT_W * OUT_H;
    localparam logic [ADDR_W-1:0] OUT_W_A  = ADDR_W'(OUT_W);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(OUT_H - 1);
    localparam logic [31:0]       DEPTH_U  = 32'(DEPTH);

    fmap_state_t       state_q, state_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic              ovf_q, ovf_d;
    logic              rvalid_q, rvalid_d;
    logic              oob_q, oob_d;

    logic              wr_req;
    logic              wr_fire;
    logic              rd_fire;
    logic              rd_oob;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] ram_rdata;

    // clear outranks any simultaneous write or read
    assign wr_req  = enable && in_valid && !clear;
    assign wr_fire = wr_req && (state_q == ST_FILL);
    assign rd_fire = rd_en && !clear && (state_q == ST_DONE);
    assign rd_oob  = 32'(rd_addr) >= DEPTH_U;
    assign waddr   = row_q * OUT_W_A + col_q;

`ifdef POOL_FMAP_RELU_EN
    assign wdata = in[DATA_W-1] ? '0 : in;
`else
    assign wdata = in;
`endif

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        ovf_d    = ovf_q;
        rvalid_d = rd_fire;
        oob_d    = oob_q;
        if (rd_fire) begin
            oob_d = rd_oob;
        end
        if (clear) begin
            state_d = ST_FILL;
            col_d   = '0;
            row_d   = '0;
            ovf_d   = 1'b0;
        end else if (wr_fire) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (wr_req && (state_q == ST_DONE)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_FILL;
            col_q    <= '0;
            row_q    <= '0;
            ovf_q    <= 1'b0;
            rvalid_q <= 1'b0;
            oob_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            ovf_q    <= ovf_d;
            rvalid_q <= rvalid_d;
            oob_q    <= oob_d;
        end
    end

    pool_fmap_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_fire),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .re_i    (rd_fire && !rd_oob),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    // out-of-range reads leave the RAM register alone and present zero
    assign rd_data    = oob_q ? '0 : ram_rdata;
    assign rd_valid   = rvalid_q;
    assign frame_done = (state_q == ST_DONE);
    assign wr_col     = col_q;
    assign wr_row     = row_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_pool_fmap_buffer.sv
// Directed self-checking bench for pool_fmap_buffer.
// Honours POOL_FMAP_RELU_EN when choosing the clamp expectations.
module tb_pool_fmap_buffer;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int W  = 14;
    localparam int H  = 14;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          in_valid;
    logic [DW-1:0] din;
    logic          clear;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          frame_done;
    logic [AW-1:0] wr_col;
    logic [AW-1:0] wr_row;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pool_fmap_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_valid   (in_valid),
        .in         (din),
        .clear      (clear),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .frame_done (frame_done),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .overflow   (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable   = 1'b1;
        in_valid = 1'b0;
        clear    = 1'b0;
        rd_en    = 1'b0;
        din      = '0;
        rd_addr  = '0;
    endtask

    task automatic push(input logic [DW-1:0] v);
        in_valid = 1'b1;
        din      = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        #2;
        n_tests++;
        if (rd_data !== 32'h0) begin
            $display("FAIL reset_rd_data: got %h expected 0", rd_data); n_fail++;
        end
        n_tests++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); n_fail++;
        end
        n_tests++;
        if (frame_done !== 1'b0) begin
            $display("FAIL reset_frame_done: got %b expected 0", frame_done); n_fail++;
        end
        n_tests++;
        if (wr_col !== 8'd0 || wr_row !== 8'd0) begin
            $display("FAIL reset_counters: got %0d,%0d expected 0,0", wr_col, wr_row); n_fail++;
        end
        n_tests++;
        if (overflow !== 1'b0) begin
            $display("FAIL reset_overflow: got %b expected 0", overflow); n_fail++;
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_fill_and_read();
        for (int i = 0; i < N; i++) begin
            push(DW'(i));
            n_tests++;
            if (frame_done !== (i == N - 1)) begin
                $display("FAIL fill_done[%0d]: got %b expected %b", i, frame_done, (i == N - 1));
                n_fail++;
            end
            if (i == 0 || i == 13 || i == 14) begin
                n_tests++;
                if (wr_col !== AW'((i + 1) % W) || wr_row !== AW'((i + 1) / W)) begin
                    $display("FAIL fill_pos[%0d]: got %0d,%0d expected %0d,%0d",
                             i, wr_col, wr_row, (i + 1) % W, (i + 1) / W);
                    n_fail++;
                end
            end
        end
        n_tests++;
        if (wr_col !== 8'd0 || wr_row !== 8'd0) begin
            $display("FAIL fill_wrap: got %0d,%0d expected 0,0", wr_col, wr_row); n_fail++;
        end
        for (int a = 0; a < N; a++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(a);
            tick();
            n_tests++;
            if (rd_valid !== 1'b1 || rd_data !== DW'(a)) begin
                $display("FAIL readback[%0d]: got v=%b d=%h expected v=1 d=%h",
                         a, rd_valid, rd_data, DW'(a));
                n_fail++;
            end
        end
        rd_en = 1'b0;
        tick();
        n_tests++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL readback_end_valid: got %b expected 0", rd_valid); n_fail++;
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 3; k++) begin
            push(32'hDEAD_0000 + DW'(k));
            n_tests++;
            if (overflow !== 1'b1 || frame_done !== 1'b1) begin
                $display("FAIL ovf_set[%0d]: got o=%b fd=%b expected o=1 fd=1",
                         k, overflow, frame_done);
                n_fail++;
            end
        end
        tick();
        tick();
        n_tests++;
        if (overflow !== 1'b1) begin
            $display("FAIL ovf_sticky: got %b expected 1", overflow); n_fail++;
        end
        rd(8'd0);
        n_tests++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
            $display("FAIL ovf_mem0: got v=%b d=%h expected v=1 d=0", rd_valid, rd_data);
            n_fail++;
        end
        rd(8'd7);
        n_tests++;
        if (rd_data !== 32'h7) begin
            $display("FAIL ovf_mem7: got %h expected 7", rd_data); n_fail++;
        end
        do_clear();
        n_tests++;
        if (overflow !== 1'b0 || frame_done !== 1'b0) begin
            $display("FAIL clear_flags: got o=%b fd=%b expected 0,0", overflow, frame_done);
            n_fail++;
        end
        n_tests++;
        if (wr_col !== 8'd0 || wr_row !== 8'd0) begin
            $display("FAIL clear_counters: got %0d,%0d expected 0,0", wr_col, wr_row);
            n_fail++;
        end
    endtask

    task automatic test_read_in_fill();
        rd(8'd5);
        n_tests++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL fill_read_valid: got %b expected 0", rd_valid); n_fail++;
        end
        n_tests++;
        if (rd_data !== 32'h7) begin
            $display("FAIL fill_read_hold: got %h expected 7", rd_data); n_fail++;
        end
    endtask

    task automatic test_enable_toggle();
        int acc;
        acc = 0;
        for (int k = 0; k < 32; k++) begin
            enable   = (k % 2 == 0);
            in_valid = 1'b1;
            din      = 1000 + DW'(k);
            tick();
            if (k % 2 == 0) acc++;
            n_tests++;
            if (wr_col !== AW'(acc % W) || wr_row !== AW'(acc / W)) begin
                $display("FAIL toggle_pos[%0d]: got %0d,%0d expected %0d,%0d",
                         k, wr_col, wr_row, acc % W, acc / W);
                n_fail++;
            end
        end
        enable = 1'b1;
        for (int a = 16; a < N; a++) begin
            din = 5000 + DW'(a);
            tick();
        end
        in_valid = 1'b0;
        n_tests++;
        if (frame_done !== 1'b1) begin
            $display("FAIL toggle_done: got %b expected 1", frame_done); n_fail++;
        end
        enable = 1'b0;
        for (int j = 0; j < 16; j++) begin
            rd(AW'(j));
            n_tests++;
            if (rd_valid !== 1'b1 || rd_data !== 1000 + DW'(2 * j)) begin
                $display("FAIL toggle_read[%0d]: got v=%b d=%0d expected v=1 d=%0d",
                         j, rd_valid, rd_data, 1000 + 2 * j);
                n_fail++;
            end
        end
        enable = 1'b1;
        rd(8'd16);
        n_tests++;
        if (rd_data !== 32'd5016) begin
            $display("FAIL toggle_read16: got %0d expected 5016", rd_data); n_fail++;
        end
        rd(8'd200);
        n_tests++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
            $display("FAIL oob_read: got v=%b d=%h expected v=1 d=0", rd_valid, rd_data);
            n_fail++;
        end
        rd(8'd195);
        n_tests++;
        if (rd_data !== 32'd5195) begin
            $display("FAIL read_last: got %0d expected 5195", rd_data); n_fail++;
        end
    endtask

    task automatic test_clear_collision();
        do_clear();
        for (int i = 0; i < N - 1; i++) push(2000 + DW'(i));
        n_tests++;
        if (wr_col !== 8'd13 || wr_row !== 8'd13) begin
            $display("FAIL pre_collide_pos: got %0d,%0d expected 13,13", wr_col, wr_row);
            n_fail++;
        end
        in_valid = 1'b1;
        din      = 32'd9999;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (frame_done !== 1'b0 || wr_col !== 8'd0 || wr_row !== 8'd0) begin
            $display("FAIL collide: got fd=%b %0d,%0d expected fd=0 0,0",
                     frame_done, wr_col, wr_row);
            n_fail++;
        end
        tick();
        n_tests++;
        if (frame_done !== 1'b0) begin
            $display("FAIL collide_stay: got %b expected 0", frame_done); n_fail++;
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 50; i++) push(DW'(i));
        n_tests++;
        if (wr_col !== 8'd8 || wr_row !== 8'd3) begin
            $display("FAIL mid_pos: got %0d,%0d expected 8,3", wr_col, wr_row); n_fail++;
        end
        n_tests++;
        if (rd_data !== 32'd5195) begin
            $display("FAIL mid_rd_hold: got %0d expected 5195", rd_data); n_fail++;
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (wr_col !== 8'd0 || wr_row !== 8'd0 || rd_data !== 32'h0 ||
            rd_valid !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0) begin
            $display("FAIL async_reset: got col=%0d row=%0d d=%h v=%b fd=%b o=%b expected all 0",
                     wr_col, wr_row, rd_data, rd_valid, frame_done, overflow);
            n_fail++;
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_relu();
        logic [DW-1:0] exp0;
`ifdef POOL_FMAP_RELU_EN
        exp0 = 32'h0000_0000;
`else
        exp0 = 32'h8000_0001;
`endif
        push(32'h8000_0001);
        push(32'h7FFF_FFFF);
        for (int i = 2; i < N; i++) push(DW'(i));
        n_tests++;
        if (frame_done !== 1'b1) begin
            $display("FAIL relu_done: got %b expected 1", frame_done); n_fail++;
        end
        rd(8'd0);
        n_tests++;
        if (rd_data !== exp0) begin
            $display("FAIL relu_neg: got %h expected %h", rd_data, exp0); n_fail++;
        end
        rd(8'd1);
        n_tests++;
        if (rd_data !== 32'h7FFF_FFFF) begin
            $display("FAIL relu_pos: got %h expected 7fffffff", rd_data); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_and_read();
        test_overflow();
        test_read_in_fill();
        test_enable_toggle();
        test_clear_collision();
        test_reset_midframe();
        test_relu();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
